// File: rtl/hoaaned_pkg.sv
// Shared types and default widths for the adder error-distance monitor.
package hoaaned_pkg;

  localparam int unsigned N_DEF     = 16;
  localparam int unsigned CNT_W_DEF = 20;
  localparam int unsigned SUM_W_DEF = N_DEF + 1 + CNT_W_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/hoaaned_err_monitor_abs_diff.sv
// Combinational absolute difference |a - b| of two unsigned W-bit values.
module abs_diff #(
  parameter int unsigned W = 17
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] d_o
);

  always_comb begin
    d_o = '0;
    if (a_i >= b_i) d_o = a_i - b_i;
    else            d_o = b_i - a_i;
  end

endmodule

// File: rtl/hoaaned_err_monitor.sv
// Measures error distance of an approximate adder over a run of N-bit samples:
// 2-stage pipeline (exact/ED register, then accumulate) driven by a run FSM.
module hoaaned_err_monitor
  import hoaaned_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned SUM_W = SUM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     op_a,
  input  logic [N-1:0]     op_b,
  input  logic [N:0]       approx_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [SUM_W-1:0] err_sum,
  output logic [N:0]       max_err
);

  state_e           state_q;
  logic [CNT_W-1:0] target_q, accepted_q, accepted_d;
  logic             s1_valid_q;
  logic [N:0]       s1_ed_q;
  logic [CNT_W-1:0] sample_q, errc_q;
  logic [SUM_W-1:0] sum_q;
  logic [N:0]       max_q;

  logic [N:0]       exact;
  logic [N:0]       ed;
  logic             xfer;

  assign exact = {1'b0, op_a} + {1'b0, op_b};

  abs_diff #(.W(N + 1)) u_abs_diff (
    .a_i (exact),
    .b_i (approx_sum),
    .d_o (ed)
  );

  assign in_ready   = (state_q == RUN) && (accepted_q < target_q);
  assign xfer       = in_valid && in_ready;
  assign accepted_d = accepted_q + CNT_W'(xfer);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      target_q   <= '0;
      accepted_q <= '0;
      s1_valid_q <= 1'b0;
      s1_ed_q    <= '0;
      sample_q   <= '0;
      errc_q     <= '0;
      sum_q      <= '0;
      max_q      <= '0;
    end else begin
      s1_valid_q <= xfer;
      if (xfer) s1_ed_q <= ed;

      if (s1_valid_q) begin
        sample_q <= sample_q + CNT_W'(1);
        if (s1_ed_q != '0) errc_q <= errc_q + CNT_W'(1);
        sum_q <= sum_q + SUM_W'(s1_ed_q);
        if (s1_ed_q > max_q) max_q <= s1_ed_q;
      end

      // Stage 1 is always empty in IDLE/DONE, so the clears below never race an update.
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= RUN;
            target_q   <= num_samples;
            accepted_q <= '0;
            sample_q   <= '0;
            errc_q     <= '0;
            sum_q      <= '0;
            max_q      <= '0;
          end
        end
        RUN: begin
          accepted_q <= accepted_d;
          if (accepted_d == target_q) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!s1_valid_q) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = (state_q == RUN) || (state_q == DRAIN);
  assign done         = (state_q == DONE);
  assign sample_count = sample_q;
  assign err_count    = errc_q;
  assign err_sum      = sum_q;
  assign max_err      = max_q;

endmodule

// File: tb/tb_hoaaned_err_monitor.sv
// Randomized and directed bench for hoaaned_err_monitor against a transfer-queue model.
module tb_hoaaned_err_monitor;

  localparam int unsigned N     = 16;
  localparam int unsigned CNT_W = 20;
  localparam int unsigned SUM_W = 37;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_samples = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     op_a = '0;
  logic [N-1:0]     op_b = '0;
  logic [N:0]       approx_sum = '0;
  logic             busy, done;
  logic [CNT_W-1:0] sample_count, err_count;
  logic [SUM_W-1:0] err_sum;
  logic [N:0]       max_err;

  hoaaned_err_monitor #(.N(N), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_samples  (num_samples),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .approx_sum   (approx_sum),
    .busy         (busy),
    .done         (done),
    .sample_count (sample_count),
    .err_count    (err_count),
    .err_sum      (err_sum),
    .max_err      (max_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: each accepted transfer is queued with the edge that captured it and
  // becomes visible in the results one edge later.
  typedef struct {
    int unsigned edge_n;
    longint unsigned ed;
  } pend_t;

  pend_t           pq[$];
  int unsigned     P = 0;
  int unsigned     m_acc, m_last;
  longint unsigned m_cnt, m_errc, m_sum, m_max;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    P++;
    #1;
  endtask

  task automatic apply_visible();
    pend_t e;
    while (pq.size() > 0 && pq[0].edge_n + 1 <= P) begin
      e = pq.pop_front();
      m_cnt++;
      if (e.ed != 0) m_errc++;
      m_sum += e.ed;
      if (e.ed > m_max) m_max = e.ed;
    end
  endtask

  task automatic check_all_zero(string tag);
    check_eq({tag, "_ready"}, 64'(in_ready), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_cnt"}, 64'(sample_count), 64'd0);
    check_eq({tag, "_errc"}, 64'(err_count), 64'd0);
    check_eq({tag, "_sum"}, 64'(err_sum), 64'd0);
    check_eq({tag, "_max"}, 64'(max_err), 64'd0);
  endtask

  // dmode: 0 random, 1 exact sums, 2 ED 2/9/4 list, 3 wrap, 4 single 3+5 vs 1
  task automatic gen_ops(int unsigned dmode, int unsigned idx);
    int unsigned ta[4];
    int unsigned tb[4];
    int unsigned ts[3];
    int ex;
    ta = '{0, 16'hFFFF, 16'h1234, 16'h8000};
    tb = '{0, 16'h0001, 16'h4321, 16'h8000};
    ts = '{28, 39, 26};
    case (dmode)
      1: begin
        op_a = 16'(ta[idx % 4]);
        op_b = 16'(tb[idx % 4]);
        approx_sum = 17'(ta[idx % 4] + tb[idx % 4]);
      end
      2: begin
        op_a = 16'd10;
        op_b = 16'd20;
        approx_sum = 17'(ts[idx % 3]);
      end
      3: begin
        op_a = '0;
        op_b = '0;
        approx_sum = 17'h1FFFF;
      end
      4: begin
        op_a = 16'h0003;
        op_b = 16'h0005;
        approx_sum = 17'h00001;
      end
      default: begin
        op_a = 16'($urandom);
        op_b = 16'($urandom);
        ex = int'(op_a) + int'(op_b);
        if ($urandom_range(0, 3) == 0) approx_sum = 17'($urandom);
        else approx_sum = 17'(ex + int'($urandom_range(0, 6)) - 3);
      end
    endcase
  endtask

  function automatic longint unsigned ref_ed();
    longint d;
    d = longint'(op_a) + longint'(op_b) - longint'(approx_sum);
    return (d < 0) ? longint'(-d) : longint'(d);
  endfunction

  // vmode: 0 continuous valid, 1 valid every other cycle, 2 random valid
  task automatic run(int unsigned n, int unsigned vmode, int unsigned dmode, bit poke_start);
    bit ready_m, dn_m, xfer;
    longint unsigned ed_m;
    int unsigned post, budget;
    start = 1'b1;
    num_samples = CNT_W'(n);
    in_valid = 1'b0;
    tick();
    start = 1'b0;
    m_acc = 0; m_last = P;
    m_cnt = 0; m_errc = 0; m_sum = 0; m_max = 0;
    pq.delete();
    post = 0;
    budget = 4 * n + 20;
    for (int unsigned c = 0; c < budget && post < 3; c++) begin
      ready_m = (m_acc < n);
      case (vmode)
        0: in_valid = 1'b1;
        1: in_valid = (c % 2 == 0);
        default: in_valid = ($urandom_range(0, 99) < 60);
      endcase
      gen_ops(dmode, m_acc);
      if (poke_start && c == 1) begin
        start = 1'b1;
        num_samples = CNT_W'(n + 7);
      end
      apply_visible();
      dn_m = (m_acc == n) && (P >= m_last + 2);
      @(negedge clk);
      check_eq("in_ready", 64'(in_ready), 64'(ready_m));
      check_eq("busy", 64'(busy), 64'(!dn_m));
      check_eq("done", 64'(done), 64'(dn_m));
      check_eq("sample_count", 64'(sample_count), m_cnt);
      check_eq("err_count", 64'(err_count), m_errc);
      check_eq("err_sum", 64'(err_sum), m_sum);
      check_eq("max_err", 64'(max_err), m_max);
      xfer = in_valid && ready_m;
      ed_m = ref_ed();
      tick();
      start = 1'b0;
      if (xfer) begin
        pq.push_back('{edge_n: P, ed: ed_m});
        m_acc++;
        if (m_acc == n) m_last = P;
      end
      if (dn_m) post++;
    end
    in_valid = 1'b0;
    if (post < 3) check_eq("run_timeout", 64'd0, 64'd1);
    check_eq("final_count", 64'(sample_count), 64'(n));
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    tick();

    // Abort mid-run after 3 transfers; reset also beats a simultaneous start/transfer.
    start = 1'b1; num_samples = 20'd10;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      gen_ops(0, 0);
      tick();
    end
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid");
    tick();
    @(negedge clk);
    check_all_zero("rst_mid2");
    tick();

    run(1, 0, 4, 1'b0);
    check_eq("single_errc", 64'(err_count), 64'd1);
    check_eq("single_sum", 64'(err_sum), 64'd7);
    check_eq("single_max", 64'(max_err), 64'd7);

    run(4, 0, 1, 1'b0);
    check_eq("exact_errc", 64'(err_count), 64'd0);
    check_eq("exact_sum", 64'(err_sum), 64'd0);

    run(3, 0, 2, 1'b1);
    check_eq("list_sum", 64'(err_sum), 64'd15);
    check_eq("list_max", 64'(max_err), 64'd9);

    run(0, 0, 0, 1'b0);
    check_eq("zero_sum", 64'(err_sum), 64'd0);

    run(5, 1, 3, 1'b0);
    check_eq("wrap_max", 64'(max_err), 64'h1FFFF);
    check_eq("wrap_sum", 64'(err_sum), 64'h1FFFF * 5);

    for (int r = 0; r < 8; r++)
      run($urandom_range(0, 12), $urandom_range(0, 2), 0, 1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
